// File: rtl/axi_burst_pkg.sv
// ============================================================================
// axi_burst_pkg : shared types and constants for the AXI4 burst engine
// Revision      : 1.0
// ============================================================================
`default_nettype none

package axi_burst_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        RD   = 3'd2,
        AW   = 3'd3,
        WD   = 3'd4,
        WB   = 3'd5
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // AXSIZE code for a full-width beat: log2 of the byte count
    function automatic logic [2:0] axsize(input int data_width);
        logic [2:0] code;
        code = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((8 << i) == data_width) begin
                code = 3'(i);
            end
        end
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_burst_engine_if.sv
// ============================================================================
// axi_burst_engine_if : AXI4 master channel set (*_m_inf) for the burst engine
// Revision            : 1.0
// ============================================================================
`default_nettype none

interface axi_burst_engine_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
);
    logic [ID_WIDTH-1:0]   awid_m_inf;
    logic [ADDR_WIDTH-1:0] awaddr_m_inf;
    logic [2:0]            awsize_m_inf;
    logic [1:0]            awburst_m_inf;
    logic [7:0]            awlen_m_inf;
    logic                  awvalid_m_inf;
    logic                  awready_m_inf;

    logic [DATA_WIDTH-1:0] wdata_m_inf;
    logic                  wlast_m_inf;
    logic                  wvalid_m_inf;
    logic                  wready_m_inf;

    logic [ID_WIDTH-1:0]   bid_m_inf;
    logic [1:0]            bresp_m_inf;
    logic                  bvalid_m_inf;
    logic                  bready_m_inf;

    logic [ID_WIDTH-1:0]   arid_m_inf;
    logic [ADDR_WIDTH-1:0] araddr_m_inf;
    logic [7:0]            arlen_m_inf;
    logic [2:0]            arsize_m_inf;
    logic [1:0]            arburst_m_inf;
    logic                  arvalid_m_inf;
    logic                  arready_m_inf;

    logic [ID_WIDTH-1:0]   rid_m_inf;
    logic [DATA_WIDTH-1:0] rdata_m_inf;
    logic [1:0]            rresp_m_inf;
    logic                  rlast_m_inf;
    logic                  rvalid_m_inf;
    logic                  rready_m_inf;

    modport master (
        output awid_m_inf, awaddr_m_inf, awsize_m_inf, awburst_m_inf, awlen_m_inf, awvalid_m_inf,
        input  awready_m_inf,
        output wdata_m_inf, wlast_m_inf, wvalid_m_inf,
        input  wready_m_inf,
        input  bid_m_inf, bresp_m_inf, bvalid_m_inf,
        output bready_m_inf,
        output arid_m_inf, araddr_m_inf, arlen_m_inf, arsize_m_inf, arburst_m_inf, arvalid_m_inf,
        input  arready_m_inf,
        input  rid_m_inf, rdata_m_inf, rresp_m_inf, rlast_m_inf, rvalid_m_inf,
        output rready_m_inf
    );

    modport slave (
        input  awid_m_inf, awaddr_m_inf, awsize_m_inf, awburst_m_inf, awlen_m_inf, awvalid_m_inf,
        output awready_m_inf,
        input  wdata_m_inf, wlast_m_inf, wvalid_m_inf,
        output wready_m_inf,
        output bid_m_inf, bresp_m_inf, bvalid_m_inf,
        input  bready_m_inf,
        input  arid_m_inf, araddr_m_inf, arlen_m_inf, arsize_m_inf, arburst_m_inf, arvalid_m_inf,
        output arready_m_inf,
        output rid_m_inf, rdata_m_inf, rresp_m_inf, rlast_m_inf, rvalid_m_inf,
        input  rready_m_inf
    );

endinterface

`default_nettype wire

// File: rtl/axi_beat_counter.sv
// ============================================================================
// axi_beat_counter : 8-bit beat counter with last-beat compare against len
// Revision         : 1.0
// ============================================================================
`default_nettype none

module axi_beat_counter (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       clr,
    input  wire logic       inc,
    input  wire logic [7:0] len,
    output logic      [7:0] cnt,
    output logic            last
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (inc) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == len);

endmodule

`default_nettype wire

// File: rtl/axi_burst_engine.sv
// ============================================================================
// axi_burst_engine : single-outstanding AXI4 INCR burst master (read or write)
// Optional response checking enabled by defining AXI_RESP_CHECK_EN.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module axi_burst_engine
    import axi_burst_pkg::*;
#(
    parameter int          ID_WIDTH   = 4,
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 128,
    parameter int unsigned AXI_ID     = 0,
    parameter int          LEN_WIDTH  = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  cmd_valid,
    output logic                       cmd_ready,
    input  wire logic                  cmd_op,
    input  wire logic [ADDR_WIDTH-1:0] cmd_addr,
    input  wire logic [LEN_WIDTH-1:0]  cmd_len,
    output logic      [DATA_WIDTH-1:0] rd_data,
    output logic                       rd_valid,
    input  wire logic                  rd_ready,
    output logic                       rd_last,
    input  wire logic [DATA_WIDTH-1:0] wr_data,
    input  wire logic                  wr_valid,
    output logic                       wr_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    axi_burst_engine_if.master         axi
);

    localparam logic [ID_WIDTH-1:0] AXI_ID_BITS = ID_WIDTH'(AXI_ID);
    localparam logic [2:0]          AXSIZE      = axsize(DATA_WIDTH);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [7:0]            len_q,   len_d;

    logic       cmd_acc;
    logic       r_hs;
    logic       w_hs;
    logic       b_hs;
    logic       cnt_inc;
    logic       cnt_last;
    logic [7:0] beat_cnt;

    assign cmd_acc = cmd_valid && cmd_ready;
    assign r_hs    = (state_q == RD) && axi.rvalid_m_inf && axi.rready_m_inf;
    assign w_hs    = (state_q == WD) && axi.wvalid_m_inf && axi.wready_m_inf;
    assign b_hs    = (state_q == WB) && axi.bvalid_m_inf;
    assign cnt_inc = r_hs || w_hs;

    axi_beat_counter u_beat_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cmd_acc),
        .inc   (cnt_inc),
        .len   (len_q),
        .cnt   (beat_cnt),
        .last  (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    len_d   = 8'(cmd_len);
                    state_d = cmd_op ? AW : AR;
                end
            end
            AR: if (axi.arready_m_inf) state_d = RD;
            RD: if (r_hs && axi.rlast_m_inf) state_d = IDLE;
            AW: if (axi.awready_m_inf) state_d = WD;
            WD: if (w_hs && cnt_last) state_d = WB;
            WB: if (b_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
        end
    end

`ifdef AXI_RESP_CHECK_EN
    logic err_q, err_d;

    // A premature rlast is flagged against the registered count, before it increments
    always_comb begin
        err_d = err_q;
        if (cmd_acc) begin
            err_d = 1'b0;
        end else begin
            if (r_hs && ((axi.rresp_m_inf != RESP_OKAY) || (axi.rid_m_inf != AXI_ID_BITS) ||
                         (axi.rlast_m_inf && !cnt_last))) begin
                err_d = 1'b1;
            end
            if (b_hs && ((axi.bresp_m_inf != RESP_OKAY) || (axi.bid_m_inf != AXI_ID_BITS))) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_resp;
    assign unused_resp = ^{axi.rresp_m_inf, axi.rid_m_inf, axi.bresp_m_inf, axi.bid_m_inf};
    assign err         = 1'b0;
`endif

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (r_hs && axi.rlast_m_inf) || b_hs;

    assign axi.arid_m_inf    = AXI_ID_BITS;
    assign axi.araddr_m_inf  = addr_q;
    assign axi.arlen_m_inf   = len_q;
    assign axi.arsize_m_inf  = AXSIZE;
    assign axi.arburst_m_inf = BURST_INCR;
    assign axi.arvalid_m_inf = (state_q == AR);

    // Read stream is gated by state so a lingering slave beat never leaks out in IDLE
    assign axi.rready_m_inf = (state_q == RD) && rd_ready;
    assign rd_valid         = (state_q == RD) && axi.rvalid_m_inf;
    assign rd_last          = (state_q == RD) && axi.rlast_m_inf;
    assign rd_data          = (state_q == RD) ? axi.rdata_m_inf : '0;

    assign axi.awid_m_inf    = AXI_ID_BITS;
    assign axi.awaddr_m_inf  = addr_q;
    assign axi.awlen_m_inf   = len_q;
    assign axi.awsize_m_inf  = AXSIZE;
    assign axi.awburst_m_inf = BURST_INCR;
    assign axi.awvalid_m_inf = (state_q == AW);

    assign axi.wvalid_m_inf = (state_q == WD) && wr_valid;
    assign axi.wlast_m_inf  = (state_q == WD) && cnt_last;
    assign axi.wdata_m_inf  = (state_q == WD) ? wr_data : '0;
    assign wr_ready         = (state_q == WD) && axi.wready_m_inf;

    assign axi.bready_m_inf = (state_q == WB);

    logic unused_cnt;
    assign unused_cnt = ^beat_cnt;

endmodule

`default_nettype wire

// File: tb/tb_axi_burst_engine.sv
// ============================================================================
// tb_axi_burst_engine : directed self-checking bench for axi_burst_engine
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_axi_burst_engine;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_op = 1'b0;
    logic [31:0]  cmd_addr = '0;
    logic [7:0]   cmd_len = '0;
    logic [127:0] rd_data;
    logic         rd_valid;
    logic         rd_ready = 1'b0;
    logic         rd_last;
    logic [127:0] wr_data = '0;
    logic         wr_valid = 1'b0;
    logic         wr_ready;
    logic         busy;
    logic         done;
    logic         err;

    int n_tests = 0;
    int n_fail  = 0;

    axi_burst_engine_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(128)) bus ();

    axi_burst_engine #(
        .ID_WIDTH   (4),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (128),
        .AXI_ID     (0),
        .LEN_WIDTH  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_last   (rd_last),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .axi       (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a read command and complete the AR handshake; leaves the DUT in RD
    task automatic start_read(input logic [31:0] addr, input logic [7:0] len);
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = addr; cmd_len = len;
        tick();
        cmd_valid = 1'b0;
        bus.arready_m_inf = 1'b1;
        tick();
        bus.arready_m_inf = 1'b0;
    endtask

    logic exp_err;
    int   beats, dones, mism_rdy, mism_dat, rdy_while_busy;
    bit   fin;

    initial begin
        bus.awready_m_inf = 1'b0; bus.wready_m_inf = 1'b0;
        bus.bid_m_inf = '0; bus.bresp_m_inf = 2'b00; bus.bvalid_m_inf = 1'b0;
        bus.arready_m_inf = 1'b0;
        bus.rid_m_inf = '0; bus.rdata_m_inf = '0; bus.rresp_m_inf = 2'b00;
        bus.rlast_m_inf = 1'b0; bus.rvalid_m_inf = 1'b0;
`ifdef AXI_RESP_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif

        // Reset state
        tick(); tick();
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_arvalid", bus.arvalid_m_inf, 0);
        check_eq("rst_awvalid", bus.awvalid_m_inf, 0);
        check_eq("rst_bready", bus.bready_m_inf, 0);
        check_eq("rst_done_err", {done, err}, 0);
        check_eq("rst_araddr", bus.araddr_m_inf, 0);
        rst_n = 1'b1;
        tick();

        // Read 0x0001_0000 len 3
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = 32'h0001_0000; cmd_len = 8'd3;
        #1 check_eq("rd_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        #1;
        check_eq("ar_valid", bus.arvalid_m_inf, 1);
        check_eq("ar_addr", bus.araddr_m_inf, 32'h0001_0000);
        check_eq("ar_len", bus.arlen_m_inf, 3);
        check_eq("ar_size", bus.arsize_m_inf, 4);
        check_eq("ar_burst", bus.arburst_m_inf, 1);
        check_eq("ar_busy_rdy", {busy, cmd_ready}, 2'b10);
        bus.arready_m_inf = 1'b1;
        tick();
        bus.arready_m_inf = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.rvalid_m_inf = 1'b1;
            bus.rdata_m_inf  = {4{32'hD000_0000 | 32'(i)}};
            bus.rlast_m_inf  = (i == 3);
            #1;
            check_eq("rd_valid", rd_valid, 1);
            check_eq("rd_data", rd_data, {4{32'hD000_0000 | 32'(i)}});
            check_eq("rd_rready", bus.rready_m_inf, 1);
            check_eq("rd_done", done, (i == 3));
            tick();
        end
        bus.rvalid_m_inf = 1'b0; bus.rlast_m_inf = 1'b0;
        #1;
        check_eq("rd_end_busy", busy, 0);
        check_eq("rd_end_done", done, 0);

        // Write 0x0001_1000 len 0 with awready held off for 5 cycles
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = 32'h0001_1000; cmd_len = 8'd0;
        tick();
        cmd_valid = 1'b0;
        wr_valid = 1'b1; wr_data = {16{8'hA5}};
        bus.wready_m_inf = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq("aw_valid_wait", bus.awvalid_m_inf, 1);
            check_eq("aw_addr_stable", bus.awaddr_m_inf, 32'h0001_1000);
            check_eq("w_before_aw", bus.wvalid_m_inf, 0);
            tick();
        end
        bus.awready_m_inf = 1'b1;
        #1 check_eq("aw_len", bus.awlen_m_inf, 0);
        tick();
        bus.awready_m_inf = 1'b0;
        #1;
        check_eq("w_valid", bus.wvalid_m_inf, 1);
        check_eq("w_last_len0", bus.wlast_m_inf, 1);
        check_eq("w_data", bus.wdata_m_inf, {16{8'hA5}});
        check_eq("w_ready", wr_ready, 1);
        tick();
        wr_valid = 1'b0; bus.wready_m_inf = 1'b0;
        #1;
        check_eq("b_ready", bus.bready_m_inf, 1);
        check_eq("b_wait_done", done, 0);
        tick();
        bus.bvalid_m_inf = 1'b1; bus.bresp_m_inf = 2'b10;
        #1 check_eq("b_done", done, 1);
        tick();
        bus.bvalid_m_inf = 1'b0; bus.bresp_m_inf = 2'b00;
        #1;
        check_eq("b_err", err, exp_err);
        check_eq("b_end_busy", busy, 0);

        // Write len 1 with cmd_valid held high throughout
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = 32'h0001_2000; cmd_len = 8'd1;
        tick();
        check_eq("err_cleared", err, 0);
        bus.awready_m_inf = 1'b1; bus.wready_m_inf = 1'b1; wr_valid = 1'b1;
        bus.bvalid_m_inf = 1'b1;
        rdy_while_busy = 0; fin = 1'b0;
        for (int c = 0; c < 50 && !fin; c++) begin
            #1;
            if (busy && cmd_ready) rdy_while_busy++;
            if (done) fin = 1'b1;
            else tick();
        end
        check_eq("hold_done_seen", fin, 1);
        check_eq("hold_ready_low", rdy_while_busy, 0);
        check_eq("hold_ready_at_done", cmd_ready, 0);
        cmd_op = 1'b0; cmd_addr = 32'h0001_3000; cmd_len = 8'd0;
        tick();
        bus.awready_m_inf = 1'b0; bus.wready_m_inf = 1'b0; wr_valid = 1'b0;
        bus.bvalid_m_inf = 1'b0;
        #1 check_eq("hold_ready_after", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        #1 check_eq("hold_second_ar", bus.arvalid_m_inf, 1);
        check_eq("hold_second_addr", bus.araddr_m_inf, 32'h0001_3000);
        bus.arready_m_inf = 1'b1;
        tick();
        bus.arready_m_inf = 1'b0;
        bus.rvalid_m_inf = 1'b1; bus.rlast_m_inf = 1'b1; bus.rdata_m_inf = 128'h77;
        #1 check_eq("hold_second_done", done, 1);
        tick();
        bus.rvalid_m_inf = 1'b0; bus.rlast_m_inf = 1'b0;

        // Read len 255 with rd_ready toggling
        start_read(32'h0002_0000, 8'd255);
        beats = 0; dones = 0; mism_rdy = 0; mism_dat = 0; fin = 1'b0;
        for (int c = 0; c < 2000 && !fin; c++) begin
            rd_ready = c[0];
            bus.rvalid_m_inf = 1'b1;
            bus.rdata_m_inf  = 128'(beats);
            bus.rlast_m_inf  = (beats == 255);
            #1;
            if (bus.rready_m_inf !== rd_ready) mism_rdy++;
            if (rd_data !== 128'(beats)) mism_dat++;
            if (bus.rready_m_inf) beats++;
            if (done) begin dones++; fin = 1'b1; end
            tick();
        end
        bus.rvalid_m_inf = 1'b0; bus.rlast_m_inf = 1'b0; rd_ready = 1'b1;
        #1;
        check_eq("l255_beats", beats, 256);
        check_eq("l255_dones", dones, 1);
        check_eq("l255_rready", mism_rdy, 0);
        check_eq("l255_data", mism_dat, 0);
        check_eq("l255_busy", busy, 0);
        check_eq("l255_err", err, 0);

        // Reset during beat 2 of a len-7 read
        start_read(32'h0003_0000, 8'd7);
        for (int i = 0; i < 2; i++) begin
            bus.rvalid_m_inf = 1'b1; bus.rdata_m_inf = 128'(i + 1);
            tick();
        end
        bus.rdata_m_inf = 128'h3;
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_rd", {bus.rready_m_inf, rd_valid, done}, 0);
        check_eq("abort_cmd_ready", cmd_ready, 1);
        check_eq("abort_regs", {bus.araddr_m_inf, bus.arlen_m_inf}, 0);
        check_eq("abort_rd_data", rd_data, 0);
        bus.rvalid_m_inf = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        start_read(32'h0004_0000, 8'd0);
        bus.rvalid_m_inf = 1'b1; bus.rlast_m_inf = 1'b1; bus.rdata_m_inf = 128'hBEEF;
        #1;
        check_eq("post_rst_data", rd_data, 128'hBEEF);
        check_eq("post_rst_done", done, 1);
        tick();
        bus.rvalid_m_inf = 1'b0; bus.rlast_m_inf = 1'b0;
        #1 check_eq("post_rst_idle", {busy, err}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/axi_burst_engine.md
Name: axi_burst_engine

Overview:
- Parametrised single-outstanding AXI4 burst master; next generation of the DRAM access path used by the picture-processing cores (EDH family).
- Turns a simple command (op, addr, len) into one INCR read or write burst on the *_m_inf channels.
- Streams read beats out and write beats in through valid/ready ports.
- Sits between a core's datapath and the DRAM slave model in PATTERN.

Parameters:
ID_WIDTH, 4, width of AXI ID fields
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 128, AXI data width; power of two, 8..1024
AXI_ID, 0, constant driven on arid/awid
LEN_WIDTH, 8, width of cmd_len; must be <= 8

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_op  in  1  0 = read, 1 = write
cmd_addr  in  ADDR_WIDTH  burst start address, DATA_WIDTH/8 aligned
cmd_len  in  LEN_WIDTH  beats minus 1
rd_data  out  DATA_WIDTH  read beat (= rdata_m_inf)
rd_valid  out  1  = rvalid_m_inf in RD state
rd_ready  in  1  drives rready_m_inf in RD state
rd_last  out  1  = rlast_m_inf
wr_data  in  DATA_WIDTH  write beat (to wdata_m_inf)
wr_valid  in  1  drives wvalid_m_inf in WD state
wr_ready  out  1  = wready_m_inf in WD state
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at transaction end
err  out  1  sticky response error (see Optional Feature)
aw*/w*/b*/ar*/r*_m_inf  full AXI4 master set, same names and widths as the EDH interface; ID_WIDTH/ADDR_WIDTH/DATA_WIDTH parametrised

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: all outputs 0, including arvalid, awvalid, wvalid, bready, rready, addr/len registers, done, err. cmd_ready = 1 after reset.
- Constant fields:
  - arburst/awburst = 2'b01 (INCR).
  - arsize/awsize = log2(DATA_WIDTH/8).
  - arid/awid = AXI_ID.
- FSM states: IDLE, AR, RD, AW, WD, WB.
- IDLE:
  - cmd_valid & cmd_ready latches addr/len/op, clears err.
  - op 0 goes to AR; op 1 goes to AW.
- AR:
  - arvalid = 1; araddr/arlen stay stable until arready.
  - arvalid & arready goes to RD next cycle.
- RD:
  - rready = rd_ready.
  - Each rvalid & rready beat increments beat_cnt.
  - Beat with rlast goes to IDLE and pulses done the same edge.
  - rlast arriving at beat_cnt != len still terminates the transaction; err is set if the feature is enabled.
- AW:
  - awvalid = 1, held stable until awready; then go to WD.
  - W never starts before AW completes.
- WD:
  - wvalid = wr_valid; wr_ready = wready; wdata = wr_data.
  - wlast = (beat_cnt == len), combinational from the registered count.
  - Handshake with wlast goes to WB.
- WB:
  - bready = 1.
  - bvalid goes to IDLE and pulses done.
- Timing and boundaries:
  - Minimum latency: cmd accept to first AR valid = 1 cycle.
  - len = 0: single-beat burst; wlast is high on the first beat.
  - len = 255: beat_cnt is 8 bits and must not wrap before wlast.
  - cmd_valid while busy is ignored (cmd_ready = 0); the command is not queued.
  - Reset asserted mid-burst aborts immediately to IDLE with all outputs at their reset values. The slave-side cleanup is the bench's responsibility.
  - Valid signals never drop before their handshake, per AXI.

Optional Feature:
- Macro: AXI_RESP_CHECK_EN.
- Defined:
  - err is set on rvalid & rready with rresp != 2'b00, on bvalid with bresp != 2'b00, and on a premature rlast.
  - Sticky until the next command is accepted.
  - rid/bid mismatch with AXI_ID also sets err.
- Undefined: err is tied 0; rresp/rid/bresp/bid are ignored.

Decomposition:
- Package axi_burst_pkg holds:
  - state enum (IDLE, AR, RD, AW, WD, WB);
  - BURST_INCR = 2'b01, RESP_OKAY = 2'b00;
  - function axsize(DATA_WIDTH).
- One natural sub-module, axi_beat_counter: beat count, last-beat compare, clear on command accept.

Test Plan:
- Read addr 0x0001_0000, len 3; slave returns D0..D3 with rlast on D3 -> arlen = 3, arsize = 4 (128b), rd_valid ×4, done pulses on the D3 edge, busy falls the next cycle.
- Write addr 0x0001_1000, len 0, wr_data 0xA5.., awready delayed 5 cycles -> awaddr stable for all 5 cycles, wvalid only after the AW handshake, wlast on beat 1, done on bvalid.
- Read len 255 with rd_ready toggling every other cycle -> rready follows rd_ready, 256 beats accepted, no count wrap, done once.
- cmd_valid held high during a write burst -> cmd_ready = 0 throughout, second command accepted only the cycle after done.
- rst_n low during beat 2 of a read with len 7 -> all outputs 0 within the same cycle; a new command after reset runs cleanly.
- With AXI_RESP_CHECK_EN, bresp = 2'b10 -> err = 1 after done, cleared on the next accept. Without the macro -> err stays 0.
